wb_port_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline's writeback stream and a long-latency unit (LLU, e.g. mul/div) that returns results out of band. Sits in the writeback stage and drives `wb_id_o` to decode/regfile. LLU results are buffered in a small FIFO. The pipeline has priority, and a starvation counter briefly stalls the pipeline so that LLU results always drain.

---
 rtl/wb_port_arbiter_pkg.sv | 30 +++
 rtl/wb_port_arbiter_llu_fifo.sv | 59 +++++
 rtl/wb_port_arbiter.sv | 111 +++++++++++
 tb/tb_wb_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback types: regfile write bundle, write-source tag and the
// buffered LLU result record.
package orion_types;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned RF_IDX_BITS = 5;

  typedef struct packed {
    logic                   rd_we;
    logic [RF_IDX_BITS-1:0] rd_s;
    logic [XLEN-1:0]        rd_v;
  } wb_id_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_PIPE = 2'd1,
    WB_SRC_LLU  = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [RF_IDX_BITS-1:0] rd_s;
    logic [XLEN-1:0]        rd_v;
  } llu_wb_t;

  typedef enum logic {
    ARB_NORMAL,
    ARB_FORCE
  } arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_llu_fifo.sv
// Small synchronous FIFO buffering LLU results until the write port is free.
// Only the head entry is visible; pointers wrap modulo DEPTH.
module wb_llu_fifo
  import orion_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  llu_wb_t data_i,
  output llu_wb_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  llu_wb_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage is not reset: discarding contents only needs the count cleared.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback has priority, buffered LLU
// results drain opportunistically or via a one-cycle forced grant on starvation.
module wb_port_arbiter
  import orion_types::*;
#(
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned LLU_FIFO_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pipe_valid_i,
  input  logic                   pipe_rd_we_i,
  input  logic [RF_IDX_BITS-1:0] pipe_rd_s_i,
  input  logic [XLEN-1:0]        pipe_rd_v_i,
  output logic                   pipe_stall_o,
  input  logic                   llu_valid_i,
  output logic                   llu_ready_o,
  input  logic [RF_IDX_BITS-1:0] llu_rd_s_i,
  input  logic [XLEN-1:0]        llu_rd_v_i,
  output wb_id_t                 wb_id_o,
  output wb_src_e                wb_src_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX) + 1;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pipe_need;
  logic             grant_pipe;
  logic             grant_llu;
  logic             llu_push;
  logic             fifo_full;
  logic             fifo_empty;
  llu_wb_t          fifo_head;
  llu_wb_t          llu_in;

  // Gating with rst_i keeps the port and LLU handshake quiet while in reset.
  assign pipe_need   = rst_i & pipe_valid_i & pipe_rd_we_i & (pipe_rd_s_i != '0);
  assign llu_ready_o = rst_i & ~fifo_full;
  assign llu_push    = llu_valid_i & llu_ready_o & (llu_rd_s_i != '0);
  assign llu_in      = '{rd_s: llu_rd_s_i, rd_v: llu_rd_v_i};

  wb_llu_fifo #(
    .DEPTH (LLU_FIFO_DEPTH)
  ) u_llu_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (llu_push),
    .pop_i   (grant_llu),
    .data_i  (llu_in),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ARB_NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    grant_pipe   = 1'b0;
    grant_llu    = 1'b0;
    pipe_stall_o = 1'b0;
    state_d      = ARB_NORMAL;
    cnt_d        = cnt_q;
    if (state_q == ARB_FORCE) begin
      grant_llu    = ~fifo_empty;
      pipe_stall_o = pipe_need;
      cnt_d        = '0;
    end else begin
      if (pipe_need)        grant_pipe = 1'b1;
      else if (!fifo_empty) grant_llu  = 1'b1;
      // A denial is a pipeline grant while an LLU result waits.
      if (grant_llu || fifo_empty) begin
        cnt_d = '0;
      end else if (grant_pipe) begin
        if (cnt_q == CNT_W'(STARVE_MAX - 1)) begin
          state_d = ARB_FORCE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    wb_id_o  = '0;
    wb_src_o = WB_SRC_NONE;
    if (grant_pipe) begin
      wb_id_o  = '{rd_we: 1'b1, rd_s: pipe_rd_s_i, rd_v: pipe_rd_v_i};
      wb_src_o = WB_SRC_PIPE;
    end else if (grant_llu) begin
      wb_id_o  = '{rd_we: 1'b1, rd_s: fifo_head.rd_s, rd_v: fifo_head.rd_v};
      wb_src_o = WB_SRC_LLU;
    end
  end

  a_force_nonempty : assert property (@(posedge clk_i) disable iff (!rst_i)
    (state_q == ARB_FORCE) |-> !fifo_empty);

  a_no_rd_collision : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(pipe_need && !fifo_empty && (pipe_rd_s_i == fifo_head.rd_s)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_wb_port_arbiter;
  import orion_types::*;

  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned DEPTH      = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pv = 1'b0, pwe = 1'b0, lv = 1'b0;
  logic [4:0]  prs = '0, lrs = '0;
  logic [31:0] prv = '0, lrv = '0;
  logic        stall, ready;
  wb_id_t      wb_id;
  wb_src_e     wb_src;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [36:0] q[$];
  int          denials = 0;
  bit          force_now = 1'b0;
  bit          exp_pipe, exp_llu, exp_stall, exp_ready;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .STARVE_MAX     (STARVE_MAX),
    .LLU_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .pipe_valid_i (pv),
    .pipe_rd_we_i (pwe),
    .pipe_rd_s_i  (prs),
    .pipe_rd_v_i  (prv),
    .pipe_stall_o (stall),
    .llu_valid_i  (lv),
    .llu_ready_o  (ready),
    .llu_rd_s_i   (lrs),
    .llu_rd_v_i   (lrv),
    .wb_id_o      (wb_id),
    .wb_src_o     (wb_src)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic eval_check();
    bit          need;
    logic [36:0] head;
    need      = rst_n && pv && pwe && (prs != 5'd0);
    exp_pipe  = 1'b0;
    exp_llu   = 1'b0;
    exp_stall = 1'b0;
    exp_ready = rst_n && (q.size() < DEPTH);
    head      = (q.size() > 0) ? q[0] : '0;
    if (rst_n) begin
      if (force_now) begin
        exp_llu   = (q.size() > 0);
        exp_stall = need;
      end else if (need) begin
        exp_pipe = 1'b1;
      end else if (q.size() > 0) begin
        exp_llu = 1'b1;
      end
    end
    check("rd_we", wb_id.rd_we, exp_pipe || exp_llu);
    check("rd_s", wb_id.rd_s, exp_pipe ? prs : (exp_llu ? head[36:32] : 5'd0));
    check("rd_v", wb_id.rd_v, exp_pipe ? prv : (exp_llu ? head[31:0] : 32'd0));
    check("src", wb_src, exp_pipe ? WB_SRC_PIPE : (exp_llu ? WB_SRC_LLU : WB_SRC_NONE));
    check("stall", stall, exp_stall);
    check("ready", ready, exp_ready);
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rs, input logic [31:0] rv,
                       input logic llv, input logic [4:0] lrs_a, input logic [31:0] lrv_a);
    @(negedge clk);
    pv = v; pwe = we; prs = rs; prv = rv;
    lv = llv; lrs = lrs_a; lrv = lrv_a;
    #1;
    eval_check();
  endtask

  task automatic advance();
    bit was_empty;
    @(posedge clk);
    if (rst_n) begin
      was_empty = (q.size() == 0);
      if (exp_llu) void'(q.pop_front());
      if (lv && exp_ready && lrs != 5'd0) q.push_back({lrs, lrv});
      if (force_now) begin
        force_now = 1'b0;
        denials   = 0;
      end else if (exp_llu || was_empty) begin
        denials = 0;
      end else if (exp_pipe) begin
        denials++;
        if (denials == int'(STARVE_MAX)) begin
          force_now = 1'b1;
          denials   = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic v, input logic we, input logic [4:0] rs, input logic [31:0] rv,
                       input logic llv, input logic [4:0] lrs_a, input logic [31:0] lrv_a);
    drive(v, we, rs, rv, llv, lrs_a, lrv_a);
    advance();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    pv = 0; pwe = 0; lv = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n_pipe, n_stall, n_llu;
    bit          hold;

    // Reset and release with idle inputs
    cycle(0, 0, 0, 0, 1, 5'd7, 32'h1);
    check("rst_ready", ready, 1'b0);
    check("rst_rd_we", wb_id.rd_we, 1'b0);
    cycle(1, 1, 5'd5, 32'h55, 0, 0, 0);
    release_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rel_ready", ready, 1'b1);
    check("rel_src", wb_src, WB_SRC_NONE);
    advance();

    // Pipeline write, then rd=x0 pipeline write
    drive(1, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
    check("pipe_x5", {wb_id.rd_we, wb_id.rd_s, wb_src}, {1'b1, 5'd5, WB_SRC_PIPE});
    advance();
    drive(1, 1, 5'd0, 32'hFFFF, 0, 0, 0);
    check("pipe_x0", wb_id.rd_we, 1'b0);
    advance();

    // LLU only: one-cycle latency, FIFO drains
    cycle(0, 0, 0, 0, 1, 5'd7, 32'h1234);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("llu_x7", {wb_id.rd_we, wb_id.rd_s, wb_src}, {1'b1, 5'd7, WB_SRC_LLU});
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("llu_drained", wb_id.rd_we, 1'b0);
    advance();

    // Starvation: LLU x3 pending while pipeline x5 needs every cycle
    cycle(1, 1, 5'd5, 32'hA5A5, 1, 5'd3, 32'h3333);
    n_pipe = 0; n_stall = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'd5, 32'hA5A5, 0, 0, 0);
      if (wb_src == WB_SRC_PIPE) n_pipe++;
      if (stall) begin
        n_stall++;
        check("starve_llu_rd", wb_id.rd_s, 5'd3);
      end
      advance();
    end
    check("starve_pipe_cnt", n_pipe, 4);
    check("starve_stall_cnt", n_stall, 1);
    drive(1, 1, 5'd5, 32'hA5A5, 0, 0, 0);
    check("starve_resume", wb_src, WB_SRC_PIPE);
    advance();
    idle(2);

    // FIFO full while pipeline blocks; third push refused; opportunistic drain
    cycle(1, 1, 5'd9, 32'h99, 1, 5'd20, 32'h2020);
    cycle(1, 1, 5'd9, 32'h99, 1, 5'd21, 32'h2121);
    drive(1, 1, 5'd9, 32'h99, 1, 5'd22, 32'h2222);
    check("full_ready", ready, 1'b0);
    advance();
    drive(1, 0, 5'd9, 32'h99, 0, 0, 0);
    check("opp_grant", {wb_src, stall}, {WB_SRC_LLU, 1'b0});
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("ready_back", ready, 1'b1);
    advance();
    idle(3);

    // Reset while in FORCE with two entries buffered
    cycle(1, 1, 5'd5, 32'h5, 1, 5'd17, 32'h17);
    cycle(1, 1, 5'd5, 32'h5, 1, 5'd18, 32'h18);
    for (int i = 0; i < 3; i++) cycle(1, 1, 5'd5, 32'h5, 0, 0, 0);
    drive(1, 1, 5'd5, 32'h5, 0, 0, 0);
    check("pre_rst_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    q.delete();
    denials = 0;
    force_now = 1'b0;
    eval_check();
    advance();
    cycle(1, 1, 5'd5, 32'h5, 1, 5'd19, 32'h19);
    release_reset();
    n_llu = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (wb_src == WB_SRC_LLU) n_llu++;
      advance();
    end
    check("post_rst_llu", n_llu, 0);

    // Random traffic; a stalled pipeline entry is re-presented unchanged
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic        v, we, llv;
      logic [4:0]  rs, lr;
      logic [31:0] rv, lvv;
      int unsigned dens;
      dens = (i / 500) % 3;
      if (hold) begin
        v = pv; we = pwe; rs = prs; rv = prv;
      end else begin
        v  = ($urandom_range(0, 3) < 3 - dens);
        we = ($urandom_range(0, 3) != 0);
        rs = 5'($urandom_range(0, 15));
        rv = $urandom;
      end
      llv = ($urandom_range(0, 2) == 0);
      lr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
      lvv = $urandom;
      drive(v, we, rs, rv, llv, lr, lvv);
      hold = exp_stall;
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
